// File: rtl/vic_irq_sequencer.sv
// APB master that programs the vectored interrupt controller after init_start and then
// services IRQs on its own: read VectAddr, present the vector, wait for the handler,
// acknowledge by writing VectAddr, let the VIC settle, and repeat.
module vic_irq_sequencer #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_F000,
    parameter int unsigned NUM_SLOTS   = 16,
    parameter logic [31:0] VECT_BASE   = 32'hFFF0_0010,
    parameter int unsigned VECT_STRIDE = 1,
    parameter logic [31:0] DEF_VECT    = 32'hFFF0_0000
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        init_start,
    input  logic [31:0] cfg_int_select,
    input  logic [31:0] cfg_int_enable,
    output logic        pselVIC,
    output logic        penable,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        nvicirq,
    input  logic        nvicfiq,
    output logic        init_busy,
    output logic        init_done,
    output logic        vect_valid,
    output logic [31:0] vect_addr,
    input  logic        vect_done,
    output logic        fiq_pending
);

    typedef enum logic [2:0] {
        StUninit, StInit, StReady, StVrd, StHandler, StVwr, StSettle
    } state_e;

    typedef enum logic [1:0] {PhSetup, PhAccess, PhGap} phase_e;

    localparam logic [31:0] OffIntSelect = 32'h00C;
    localparam logic [31:0] OffIntEnable = 32'h010;
    localparam logic [31:0] OffVectReg   = 32'h030;
    localparam logic [31:0] OffDefVect   = 32'h034;
    localparam logic [31:0] OffVectAddr  = 32'h100;
    localparam logic [31:0] OffVectCntl  = 32'h200;

    // Write index 0: IntSelect, 1: DefVectAddr, 2..2N+1: slot pairs, 2N+2: IntEnable
    localparam logic [5:0] LastIdx = 6'(2 * NUM_SLOTS + 2);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [5:0]  idx_q, idx_d;
    logic        settle_q, settle_d;
    logic [31:0] sel_q, sel_d;
    logic [31:0] en_q, en_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        init_done_q, init_done_d;
    logic        vect_valid_q, vect_valid_d;
    logic [31:0] vect_addr_q, vect_addr_d;
    logic        fiq_q;

    function automatic logic [31:0] init_addr(input logic [5:0] idx);
        logic [4:0] rel;
        logic [3:0] slot;
        rel  = idx[4:0] - 5'd2;
        slot = rel[4:1];
        if (idx == 6'd0)         return BASE_ADDR + OffIntSelect;
        else if (idx == 6'd1)    return BASE_ADDR + OffDefVect;
        else if (idx == LastIdx) return BASE_ADDR + OffIntEnable;
        else if (!rel[0])        return BASE_ADDR + OffVectAddr + {26'd0, slot, 2'b00};
        else                     return BASE_ADDR + OffVectCntl + {26'd0, slot, 2'b00};
    endfunction

    function automatic logic [31:0] init_data(input logic [5:0] idx, input logic [31:0] sel,
                                              input logic [31:0] en);
        logic [4:0] rel;
        logic [3:0] slot;
        rel  = idx[4:0] - 5'd2;
        slot = rel[4:1];
        if (idx == 6'd0)         return sel;
        else if (idx == 6'd1)    return DEF_VECT;
        else if (idx == LastIdx) return en;
        else if (!rel[0])        return VECT_BASE + 32'(slot) * VECT_STRIDE;
        else                     return 32'h20 | {28'd0, slot};
    endfunction

    // State and bus registers; synchronous active-low reset drops the bus to idle at once
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q      <= StUninit;
            phase_q      <= PhSetup;
            idx_q        <= '0;
            settle_q     <= 1'b0;
            sel_q        <= '0;
            en_q         <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            init_done_q  <= 1'b0;
            vect_valid_q <= 1'b0;
            vect_addr_q  <= '0;
            fiq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            init_done_q  <= init_done_d;
            vect_valid_q <= vect_valid_d;
            vect_addr_q  <= vect_addr_d;
            fiq_q        <= ~nvicfiq;
        end
    end

    // Next-state and next bus values; the bus registers hold whatever phase is shown next cycle
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        sel_d        = sel_q;
        en_d         = en_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        init_done_d  = init_done_q;
        vect_valid_d = vect_valid_q;
        vect_addr_d  = vect_addr_q;

        case (state_q)
            StUninit, StReady: begin
                if (init_start) begin
                    state_d     = StInit;
                    phase_d     = PhSetup;
                    idx_d       = '0;
                    sel_d       = cfg_int_select;
                    en_d        = cfg_int_enable;
                    init_done_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = 1'b1;
                    paddr_d     = init_addr(6'd0);
                    pwdata_d    = cfg_int_select;
                end else if (state_q == StReady && !nvicirq) begin
                    state_d   = StVrd;
                    phase_d   = PhSetup;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = BASE_ADDR + OffVectReg;
                    pwdata_d  = '0;
                end
            end
            StInit: begin
                case (phase_q)
                    PhSetup: begin
                        penable_d = 1'b1;
                        phase_d   = PhAccess;
                    end
                    PhAccess: begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        pwrite_d  = 1'b0;
                        paddr_d   = BASE_ADDR;
                        phase_d   = PhGap;
                        if (idx_q == LastIdx) init_done_d = 1'b1;
                    end
                    default: begin
                        if (idx_q == LastIdx) begin
                            state_d = StReady;
                        end else begin
                            idx_d    = idx_q + 6'd1;
                            phase_d  = PhSetup;
                            psel_d   = 1'b1;
                            pwrite_d = 1'b1;
                            paddr_d  = init_addr(idx_q + 6'd1);
                            pwdata_d = init_data(idx_q + 6'd1, sel_q, en_q);
                        end
                    end
                endcase
            end
            StVrd: begin
                if (phase_q == PhSetup) begin
                    penable_d = 1'b1;
                    phase_d   = PhAccess;
                end else begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    paddr_d      = BASE_ADDR;
                    vect_addr_d  = prdata;
                    vect_valid_d = 1'b1;
                    state_d      = StHandler;
                end
            end
            StHandler: begin
                if (vect_done && vect_valid_q) begin
                    vect_valid_d = 1'b0;
                    state_d      = StVwr;
                    phase_d      = PhSetup;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    pwrite_d     = 1'b1;
                    paddr_d      = BASE_ADDR + OffVectReg;
                    pwdata_d     = '0;
                end
            end
            StVwr: begin
                if (phase_q == PhSetup) begin
                    penable_d = 1'b1;
                    phase_d   = PhAccess;
                end else begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = BASE_ADDR;
                    settle_d  = 1'b0;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                // Two idle cycles so the VIC can re-arbitrate before nvicirq is sampled again
                if (!settle_q) settle_d = 1'b1;
                else           state_d  = StReady;
            end
            default: state_d = StUninit;
        endcase
    end

    assign pselVIC     = psel_q;
    assign penable     = penable_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign init_busy   = (state_q == StInit);
    assign init_done   = init_done_q;
    assign vect_valid  = vect_valid_q;
    assign vect_addr   = vect_addr_q;
    assign fiq_pending = fiq_q;

endmodule

// File: tb/tb_vic_irq_sequencer.sv
// Directed bench for vic_irq_sequencer: init write sequence, IRQ service timing, ignored
// inputs, FIQ passthrough and reset in the middle of a transfer.
module tb_vic_irq_sequencer;

    localparam logic [31:0] Base = 32'hFFFF_F000;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        init_start;
    logic [31:0] cfg_int_select;
    logic [31:0] cfg_int_enable;
    logic        pselVIC;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        nvicirq;
    logic        nvicfiq;
    logic        init_busy;
    logic        init_done;
    logic        vect_valid;
    logic [31:0] vect_addr;
    logic        vect_done;
    logic        fiq_pending;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int bus_cycles = 0;
    int rd_count = 0;
    int bc;
    logic [63:0] wr_log[$];
    logic [63:0] exp_log[$];

    always #5 pclk = ~pclk;

    vic_irq_sequencer dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .init_start     (init_start),
        .cfg_int_select (cfg_int_select),
        .cfg_int_enable (cfg_int_enable),
        .pselVIC        (pselVIC),
        .penable        (penable),
        .paddr          (paddr),
        .pwrite         (pwrite),
        .pwdata         (pwdata),
        .prdata         (prdata),
        .nvicirq        (nvicirq),
        .nvicfiq        (nvicfiq),
        .init_busy      (init_busy),
        .init_done      (init_done),
        .vect_valid     (vect_valid),
        .vect_addr      (vect_addr),
        .vect_done      (vect_done),
        .fiq_pending    (fiq_pending)
    );

    // Slave-side monitor, sampled mid-cycle
    always @(negedge pclk) begin
        if (pselVIC) bus_cycles++;
        if (pselVIC && penable && pwrite) wr_log.push_back({paddr, pwdata});
        if (pselVIC && penable && !pwrite) rd_count++;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input logic [31:0] sel, input logic [31:0] en);
        exp_log.delete();
        exp_log.push_back({Base + 32'h00C, sel});
        exp_log.push_back({Base + 32'h034, 32'hFFF0_0000});
        for (int s = 0; s < 16; s++) begin
            exp_log.push_back({Base + 32'h100 + 32'(4 * s), 32'hFFF0_0010 + 32'(s)});
            exp_log.push_back({Base + 32'h200 + 32'(4 * s), 32'h20 + 32'(s)});
        end
        exp_log.push_back({Base + 32'h010, en});
    endtask

    task automatic cmp_log(input string tag);
        logic [63:0] a;
        logic [63:0] e;
        check({tag, "_count"}, 32'(wr_log.size()), 32'd35);
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            a = wr_log[i];
            e = exp_log[i];
            check($sformatf("%s_addr%0d", tag, i), a[63:32], e[63:32]);
            check($sformatf("%s_data%0d", tag, i), a[31:0], e[31:0]);
        end
    endtask

    initial begin
        presetn        = 1'b0;
        init_start     = 1'b0;
        cfg_int_select = '0;
        cfg_int_enable = '0;
        prdata         = '0;
        nvicirq        = 1'b1;
        nvicfiq        = 1'b1;
        vect_done      = 1'b0;
        repeat (3) tick();

        check("rst_psel", {31'd0, pselVIC}, 32'd0);
        check("rst_penable", {31'd0, penable}, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_pwrite", {31'd0, pwrite}, 32'd0);
        check("rst_flags", {28'd0, init_busy, init_done, vect_valid, fiq_pending}, 32'd0);
        check("rst_vect_addr", vect_addr, 32'd0);

        // Configuration sequence
        presetn        = 1'b1;
        cfg_int_select = 32'hFFFF_0000;
        cfg_int_enable = 32'h00FF_FFFF;
        prdata         = 32'hFFF0_0013;
        tick();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        cfg_int_select = 32'h1234_5678; // must not matter after acceptance
        cfg_int_enable = 32'h8765_4321;
        cyc = 1;
        check("c1_psel", {31'd0, pselVIC}, 32'd1);
        check("c1_penable", {31'd0, penable}, 32'd0);
        check("c1_pwrite", {31'd0, pwrite}, 32'd1);
        check("c1_paddr", paddr, Base + 32'h00C);
        check("c1_pwdata", pwdata, 32'hFFFF_0000);
        check("c1_busy_done", {30'd0, init_busy, init_done}, 32'd2);
        tick();
        check("c2_penable", {31'd0, penable}, 32'd1);
        check("c2_paddr", paddr, Base + 32'h00C);
        check("c2_pwdata", pwdata, 32'hFFFF_0000);
        tick();
        check("c3_gap", {30'd0, pselVIC, penable}, 32'd0);
        check("c3_pwrite", {31'd0, pwrite}, 32'd0);
        check("c3_paddr", paddr, Base);
        tick();
        check("c4_paddr", paddr, Base + 32'h034);
        check("c4_pwdata", pwdata, 32'hFFF0_0000);

        // IRQ asserted during init must wait for the sequence to finish
        run_to(50);
        nvicirq = 1'b0;
        run_to(104);
        check("c104_done", {31'd0, init_done}, 32'd0);
        check("c104_reads", 32'(rd_count), 32'd0);
        run_to(106);
        check("c106_done", {31'd0, init_done}, 32'd1);
        check("c106_busy", {31'd0, init_busy}, 32'd0);
        check("c106_reads", 32'(rd_count), 32'd0);
        build_exp(32'hFFFF_0000, 32'h00FF_FFFF);
        cmp_log("init1");

        // First IRQ service: sampled at edge 106
        tick();
        check("vrd_setup", {29'd0, pselVIC, penable, pwrite}, 32'b100);
        check("vrd_paddr", paddr, Base + 32'h030);
        tick();
        check("vrd_access", {29'd0, pselVIC, penable, pwrite}, 32'b110);
        tick();
        check("c109_valid", {31'd0, vect_valid}, 32'd1);
        check("c109_vect", vect_addr, 32'hFFF0_0013);
        check("c109_psel", {31'd0, pselVIC}, 32'd0);
        bc = bus_cycles;

        // init_start in HANDLER is ignored
        run_to(110);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check("hdl_busy", {31'd0, init_busy}, 32'd0);
        check("hdl_done", {31'd0, init_done}, 32'd1);
        check("hdl_valid", {31'd0, vect_valid}, 32'd1);
        run_to(113);
        check("hdl_quiet", 32'(bus_cycles), 32'(bc));
        check("hdl_no_ack", 32'(wr_log.size()), 32'd35);

        // Acknowledge: vect_done sampled at edge 113, irq still low
        vect_done = 1'b1;
        tick();
        vect_done = 1'b0;
        prdata    = 32'hFFF0_0012;
        check("ack_setup", {29'd0, pselVIC, penable, pwrite}, 32'b101);
        check("ack_paddr", paddr, Base + 32'h030);
        check("ack_pwdata", pwdata, 32'd0);
        check("ack_valid", {31'd0, vect_valid}, 32'd0);
        check("ack_vect_hold", vect_addr, 32'hFFF0_0013);
        tick();
        check("ack_access", {29'd0, pselVIC, penable, pwrite}, 32'b111);
        tick();
        check("c116_idle", {31'd0, pselVIC}, 32'd0);
        tick();
        check("c117_idle", {31'd0, pselVIC}, 32'd0);
        tick();
        check("c118_idle", {31'd0, pselVIC}, 32'd0);
        tick();
        check("c119_setup", {29'd0, pselVIC, penable, pwrite}, 32'b100);
        check("c119_paddr", paddr, Base + 32'h030);
        tick();
        tick();
        check("c121_valid", {31'd0, vect_valid}, 32'd1);
        check("c121_vect", vect_addr, 32'hFFF0_0012);
        check("c121_wr_count", 32'(wr_log.size()), 32'd36);
        check("c121_ack_entry", wr_log[wr_log.size() - 1][63:32], Base + 32'h030);

        // Second acknowledge with irq released, then spurious vect_done in READY
        nvicirq   = 1'b1;
        vect_done = 1'b1;
        tick();
        vect_done = 1'b0;
        run_to(130);
        check("c130_wr_count", 32'(wr_log.size()), 32'd37);
        check("c130_reads", 32'(rd_count), 32'd2);
        check("c130_valid", {31'd0, vect_valid}, 32'd0);
        bc = bus_cycles;
        vect_done = 1'b1;
        tick();
        vect_done = 1'b0;
        run_to(135);
        check("spur_done_quiet", 32'(bus_cycles), 32'(bc));
        check("spur_done_valid", {31'd0, vect_valid}, 32'd0);

        // FIQ is passive
        nvicfiq = 1'b0;
        tick();
        check("fiq_set", {31'd0, fiq_pending}, 32'd1);
        tick();
        check("fiq_quiet", 32'(bus_cycles), 32'(bc));
        nvicfiq = 1'b1;
        tick();
        check("fiq_clr", {31'd0, fiq_pending}, 32'd0);

        // Re-init from READY, then reset during the first ACCESS
        run_to(140);
        cfg_int_select = 32'h0000_00AA;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check("reinit_setup", {31'd0, pselVIC}, 32'd1);
        check("reinit_paddr", paddr, Base + 32'h00C);
        check("reinit_flags", {30'd0, init_busy, init_done}, 32'd2);
        tick();
        check("reinit_access", {31'd0, penable}, 32'd1);
        presetn = 1'b0;
        tick();
        check("mrst_bus", {29'd0, pselVIC, penable, pwrite}, 32'd0);
        check("mrst_paddr", paddr, 32'd0);
        check("mrst_pwdata", pwdata, 32'd0);
        check("mrst_flags", {29'd0, init_busy, init_done, vect_valid}, 32'd0);
        check("mrst_vect", vect_addr, 32'd0);
        presetn = 1'b1;
        nvicirq = 1'b0;
        bc = bus_cycles;
        repeat (5) tick();
        check("uninit_ignores_irq", 32'(bus_cycles), 32'(bc));
        nvicirq = 1'b1;

        // Fresh configuration reproduces the full sequence
        wr_log.delete();
        cfg_int_select = 32'h0000_00F0;
        cfg_int_enable = 32'h0000_1234;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        cyc = 1;
        run_to(106);
        check("init2_done", {31'd0, init_done}, 32'd1);
        check("init2_idle", {31'd0, pselVIC}, 32'd0);
        build_exp(32'h0000_00F0, 32'h0000_1234);
        cmp_log("init2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vic_irq_sequencer.md
# vic_irq_sequencer

APB master controller that configures and services the vectored interrupt controller (`vic_top`) on the same `pclk` domain. On `init_start` it programs IntSelect, DefVectAddr, all vector address/control slots and IntEnable. It then autonomously services IRQs: read VectAddr, hand the vector to the handler interface, wait for completion, write VectAddr to acknowledge. It sits between the CPU-side handler logic and the VIC's APB slave port, replacing CPU-issued register traffic.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_F000, VIC base address; register offsets are added to this.
- `NUM_SLOTS`, 16, number of vector slots programmed (1..16).
- `VECT_BASE`, 32'hFFF0_0010, VectAddr value for slot 0.
- `VECT_STRIDE`, 1, VectAddr increment per slot.
- `DEF_VECT`, 32'hFFF0_0000, value written to DefVectAddr.

Ports:
- `pclk` in 1: clock; everything is on the rising edge.
- `presetn` in 1: reset, synchronous, active-low.
- `init_start` in 1: single-cycle pulse that starts the configuration sequence.
- `cfg_int_select` in 32: IntSelect value (1 = FIQ).
- `cfg_int_enable` in 32: IntEnable value.
- `pselVIC` out 1: APB select.
- `penable` out 1: APB enable.
- `paddr` out 32: APB address.
- `pwrite` out 1: APB write.
- `pwdata` out 32: APB write data.
- `prdata` in 32: APB read data.
- `nvicirq` in 1: VIC IRQ, active-low.
- `nvicfiq` in 1: VIC FIQ, active-low.
- `init_busy` out 1: configuration sequence in progress.
- `init_done` out 1: configuration complete; sticky until reset or the next `init_start`.
- `vect_valid` out 1: `vect_addr` holds the vector of the IRQ being serviced.
- `vect_addr` out 32: vector captured from VectAddr (offset 0x030).
- `vect_done` in 1: pulse from the handler signalling that service is finished.
- `fiq_pending` out 1: registered copy of `~nvicfiq`.

## Operation
- Reset values: all outputs 0, `paddr`/`pwdata` 0, FSM in `UNINIT`.
- APB transfer, always 3 cycles, with no wait states:
  - SETUP: `pselVIC`=1, `penable`=0, with `paddr`/`pwrite`/`pwdata` valid.
  - ACCESS: `pselVIC`=1, `penable`=1.
  - GAP: `pselVIC`=0, `penable`=0, `pwrite`=0, `paddr`=BASE_ADDR.
  - Address, data and direction stay stable from SETUP through ACCESS.
  - Read data is captured on the edge that ends ACCESS.
- Init sequence uses `NUM_SLOTS`*2+3 writes, in this order:
  - IntSelect (+0x00C) = `cfg_int_select`.
  - DefVectAddr (+0x034) = `DEF_VECT`.
  - For i = 0..NUM_SLOTS-1: VectAddr i (+0x100+4i) = `VECT_BASE`+i*`VECT_STRIDE`, then VectCntl i (+0x200+4i) = 32'h20 | i.
  - IntEnable (+0x010) = `cfg_int_enable`, written last so that no source is enabled before its vector exists.
  - `cfg_*` values are sampled when `init_start` is accepted.
- FSM states and transitions:
  - `UNINIT` to `INIT` on `init_start`.
  - `INIT` (write loop) to `READY` after the last GAP.
  - `READY` to `VRD` when `nvicirq`=0 is sampled; to `INIT` on `init_start`. `init_start` has priority if both occur in the same cycle.
  - `VRD` is the read of +0x030. `vect_addr` is loaded and `vect_valid` set on exit to `HANDLER`.
  - `HANDLER` waits for `vect_done`, then goes to `VWR`.
  - `VWR` writes +0x030 with data 0 (the acknowledge), then goes to `SETTLE`.
  - `SETTLE` lasts 2 cycles with the bus idle, then returns to `READY`. This lets the VIC update priority and `nvicirq` before re-sampling.
- `vect_valid` clears on the cycle after `vect_done` is accepted. `vect_addr` holds its value until the next read.
- Ignored inputs:
  - `vect_done` is ignored unless `vect_valid`=1.
  - `init_start` is ignored in every state except `UNINIT` and `READY`.
  - `nvicirq` is ignored outside `READY`.
- `init_busy`=1 only in `INIT`. `init_done` clears on `init_start` and sets on the cycle after the final IntEnable ACCESS.
- `fiq_pending` is passive: no APB traffic is generated for FIQ.
- A reset in the middle of a transfer abandons it. The bus drops to idle on the next edge and configuration must be re-run.

## Timing
- Init (NUM_SLOTS=16): 35 transfers × 3 = 105 cycles.
  - `init_start` accepted at edge 0 → first SETUP visible in cycle 1.
  - `init_done`=1 after edge 105.
- IRQ latency: `nvicirq`=0 sampled at edge k → SETUP in cycle k+1, ACCESS in k+2, `vect_valid`=1 in cycle k+3.
- Acknowledge: `vect_done` sampled at edge m → VWR SETUP in cycle m+1. Back in `READY` at edge m+5, so the earliest next IRQ SETUP is at m+6.
- `fiq_pending` has 1-cycle latency.

## Test plan
- Reset, pulse `init_start` with select=32'hFFFF_0000, enable=32'h00FF_FFFF → 35 writes in order, including +0x104 = FFF0_0011 and +0x204 = 0x21. Last write is +0x010 = 00FF_FFFF. `init_done` rises after 105 cycles.
- Slave model with `nvicirq` driven low and VectAddr read returning FFF0_0013 → `vect_valid`=1 with `vect_addr`=FFF0_0013 three cycles later. No ack write occurs until `vect_done`, then a write to +0x030 follows.
- `nvicirq` still low after the ack (lower-priority source pending) → a second read starts only after `SETTLE`, and the new vector is presented.
- `vect_done` pulsed while `vect_valid`=0, and `init_start` pulsed in `HANDLER` → no bus activity and no state change.
- `nvicirq` low during `INIT` → no read until `init_done`, then serviced.
- `presetn` low during an ACCESS → all outputs 0 the next cycle, FSM in `UNINIT`. A fresh `init_start` then reproduces the full sequence.
